pc_reg: RTL and testbench
=========================

// Module: pc_reg
// PURPOSE
//   Program-counter state register of the instruction-fetch stage.
//   Captures the next-PC value from the next-PC mux each clock and presents it to instruction memory / I-cache.
//   Update is gated by the I-cache hit flag, so a miss stalls fetch by holding the current PC.
//   Asynchronous active-low reset forces the reset vector.
// PARAMETERS
//   WIDTH     32            PC width in bits
//   RESET_PC  32'h00000000  value loaded on reset
//   ALIGN     2             number of LSBs forced to zero (word alignment)
// PORTS (positional order: pcOut, pc, hit, clk, rstn)
//   clk    in   1      rising-edge clock
//   rstn   in   1      reset, asynchronous, active-low
//   pcOut  out  WIDTH  current PC, registered
//   pc     in   WIDTH  next-PC candidate
//   hit    in   1      1 = I-cache hit, advance PC; 0 = stall, hold PC
// BEHAVIOUR
//   - One clock (clk); reset is asynchronous and active-low (rstn).
//   - rstn=0: pcOut = RESET_PC immediately, independent of clk; held while rstn=0.
//   - Reset release: no change until the next rising clk edge.
//   - Rising clk edge with rstn=1:
//       - hit==1: pcOut <= {pc[WIDTH-1:ALIGN], ALIGN'b0}.
//       - hit==0 (or X/Z): pcOut holds; only a definite 1 loads.
//   - Latency: 1 cycle from pc/hit to pcOut; no combinational path from inputs to pcOut.
//   - Alignment: pc LSBs [ALIGN-1:0] are discarded, so pcOut is always word-aligned.
//       - RESET_PC is also stored with its low ALIGN bits cleared.
//   - Width: no arithmetic inside; pc is taken as-is above ALIGN.
//       - pc=32'hFFFFFFFF loads 32'hFFFFFFFC (no wrap logic).
//   - Simultaneous events:
//       - rstn asserted on a clk edge: reset wins, pcOut = RESET_PC.
//       - Reset mid-stall: stall state discarded, pcOut = RESET_PC.
//   - pcOut is driven only by the register; it is never X after the first reset.
// TESTING
//   1. rstn=0, pc=0, hit=1 for 2 cycles -> pcOut=0x00000000 throughout.
//   2. Release rstn, pc=4, hit=1 -> pcOut=0x00000004 after the first rising edge, not before.
//   3. pcOut=4, pc=8, hit=0 for 3 edges -> pcOut stays 0x00000004.
//      Then hit=1 -> 0x00000008 on the next edge.
//   4. pc=0x00000007, hit=1 -> pcOut=0x00000004.
//      pc=0xFFFFFFFF, hit=1 -> pcOut=0xFFFFFFFC.
//   5. pcOut=0x100, drop rstn between clock edges -> pcOut=0x0 within the same time step (no edge needed).
//      Raise rstn mid-cycle -> pcOut stays 0x0 until the next edge loads pc.
//   6. Running counter: pc=pcOut+4, hit toggling randomly over 2000 half-periods of 25 ns.
//      -> pcOut advances by 4 only on edges with hit=1.
//      -> Scoreboard matches exactly.

Source files
------------

// File: rtl/pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg -- program-counter state register of the instruction-fetch stage.
//
// Captures the next-PC candidate from the next-PC mux on every rising clock
// edge on which the I-cache reports a hit. On a miss the current PC is held,
// which stalls fetch. The captured value always has its low ALIGN bits
// cleared, so the PC presented to instruction memory is word-aligned.
//
// Ports
//   pcOut  out [WIDTH-1:0]  current PC, straight from the register
//   pc     in  [WIDTH-1:0]  next-PC candidate
//   hit    in               1 = I-cache hit, advance; anything else = hold
//   clk    in               rising-edge clock
//   rstn   in               asynchronous active-low reset, loads RESET_PC
// -----------------------------------------------------------------------------
module pc_reg #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      ALIGN    = 2
) (
  output logic [WIDTH-1:0] pcOut,
  input  logic [WIDTH-1:0] pc,
  input  logic             hit,
  input  logic             clk,
  input  logic             rstn
);

  // Mask with the low ALIGN bits cleared. Built arithmetically rather than by
  // concatenation so ALIGN = 0 still elaborates (mask becomes all ones).
  localparam logic [WIDTH-1:0] ALIGN_MASK    = ~((WIDTH'(1) << ALIGN) - WIDTH'(1));
  // The reset vector obeys the same alignment as any loaded PC.
  localparam logic [WIDTH-1:0] RESET_ALIGNED = RESET_PC & ALIGN_MASK;

  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_q;

  // Only a definite 1 on hit advances: an X/Z hit makes the if-condition
  // unknown, which falls through to the hold value.
  always_comb begin
    pc_d = pc_q;
    if (hit == 1'b1) pc_d = pc & ALIGN_MASK;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pc_q <= RESET_ALIGNED;
    else       pc_q <= pc_d;
  end

  // Output comes only from the register: no input-to-output path.
  assign pcOut = pc_q;

endmodule

// File: tb/tb_pc_reg.sv
// -----------------------------------------------------------------------------
// tb_pc_reg -- scoreboard bench for pc_reg.
//
// A reference model pushes the expected PC after every rising edge; directed
// mid-cycle checks (asynchronous reset, reset release) push their expectation
// directly and raise chk_ev. A single monitor pops and compares every entry.
// -----------------------------------------------------------------------------
module tb_pc_reg;

  localparam int unsigned WIDTH    = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] val;
    int          id;   // 0 = edge sample, >0 = directed mid-cycle check
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [31:0] pc = '0;
  logic        hit = 1'b0;
  logic [31:0] pcOut;

  exp_t        exp_q[$];
  event        chk_ev;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model_pc = RESET_PC;

  pc_reg #(.WIDTH(WIDTH), .RESET_PC(RESET_PC), .ALIGN(2)) dut (
    .pcOut (pcOut),
    .pc    (pc),
    .hit   (hit),
    .clk   (clk),
    .rstn  (rstn)
  );

  always #25 clk = ~clk;

  // Reference model: the PC is the last word-aligned candidate accepted on a
  // hit edge, or the reset vector since the most recent reset.
  always @(negedge rstn) model_pc = RESET_PC & 32'hFFFF_FFFC;

  always @(posedge clk) begin
    #1;  // see the edge as the register does, including a reset dropped on it
    if (!rstn)           model_pc = RESET_PC & 32'hFFFF_FFFC;
    else if (hit === 1'b1) model_pc = {pc[31:2], 2'b00};
    exp_q.push_back('{val: model_pc, id: 0});
  end

  // Monitor: one pop per edge sample or directed check.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      if (clk) #2; else #1;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL underflow t=%0t: got pcOut=%08h with no expected entry", $time, pcOut);
      end else begin
        e = exp_q.pop_front();
        if (pcOut !== e.val) begin
          n_err++;
          $display("FAIL %s%0d t=%0t: pcOut=%08h expected %08h",
                   (e.id == 0) ? "edge" : "check", e.id, $time, pcOut, e.val);
        end
      end
    end
  end

  task automatic drive(input logic [31:0] p, input logic h);
    @(negedge clk);
    pc  = p;
    hit = h;
  endtask

  task automatic check_now(input logic [31:0] v, input int id);
    exp_q.push_back('{val: v, id: id});
    -> chk_ev;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d vectors so far", n_vec);
    $fatal(1, "timeout");
  end

  initial begin
    // 1. Reset held for two edges with a live hit and candidate.
    #1 rstn = 1'b0;
    #9 check_now(32'h0, 1);
    drive(32'h0, 1'b1);
    drive(32'h0, 1'b1);

    // 2. Release mid-cycle: no change until the next edge.
    drive(32'h4, 1'b1);
    rstn = 1'b1;
    #10 check_now(32'h0, 2);

    // 3. Stall for three edges, then advance.
    drive(32'h8, 1'b0);
    drive(32'h8, 1'b0);
    drive(32'h8, 1'b0);
    drive(32'h8, 1'b1);

    // 4. Alignment and top-of-range.
    drive(32'h0000_0007, 1'b1);
    drive(32'hFFFF_FFFF, 1'b1);
    drive(32'h1234_5679, 1'b0);

    // 5. Asynchronous reset between edges, release mid-cycle.
    drive(32'h100, 1'b1);
    drive(32'h200, 1'b1);
    #5  rstn = 1'b0;
    check_now(32'h0, 3);
    #5  rstn = 1'b1;
    #5  check_now(32'h0, 4);

    // Reset during a stall: stall state discarded, reset held across an edge.
    drive(32'h300, 1'b0);
    drive(32'h300, 1'b0);
    #10 rstn = 1'b0;
    check_now(32'h0, 5);
    drive(32'h300, 1'b1);
    rstn = 1'b1;

    // Reset asserted exactly on a rising edge with a hit pending: reset wins.
    drive(32'h440, 1'b1);
    drive(32'h550, 1'b1);
    @(posedge clk);
    rstn = 1'b0;
    drive(32'h660, 1'b1);
    rstn = 1'b1;

    // 6. Running counter, random hit, 2000 half-periods.
    for (int i = 0; i < 1000; i++) drive(pcOut + 32'd4, 1'($urandom_range(0, 1)));

    // Random candidates with random low bits and random hit.
    for (int i = 0; i < 200; i++) drive($urandom, 1'($urandom_range(0, 1)));

    drive(32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
